dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder that sits on the far end of the CPU data bus and serves the execute stage's one-cycle load/store request pulses. Requests are captured into a 2-entry in-order queue and serviced against a local word-organised RAM, with a programmable number of wait states. Each request produces a single-cycle `cpu_ack` carrying the read word, or an error for an out-of-range address. Lane extraction and sign extension of load data stay in the CPU; this block returns the raw aligned word.

## Interface
- `ADDR_WIDTH`, 14: word-address bits; RAM holds 2^ADDR_WIDTH 32-bit words.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; must be a multiple of 4·2^ADDR_WIDTH.
- `WAIT_STATES`, 1: extra cycles per access, range 0..7.
- `clock`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset (0 = in reset).
- `cpu_request`  input  1  one-cycle request pulse.
- `cpu_addr`  input  32  byte address.
- `cpu_write`  input  1  1 = store, 0 = load.
- `cpu_byte_enable`  input  4  store lane mask; ignored for loads.
- `cpu_wdata`  input  32  store data, already lane-aligned; bytes outside the mask are don't-care.
- `cpu_size`  input  2  00 = byte, 01 = half, 10 = word. Carried through the queue; not otherwise used.
- `cpu_ack`  output  1  one-cycle completion pulse, one per accepted request, in order.
- `cpu_rdata`  output  32  word at `{addr[31:2],2'b00}`, valid only while `cpu_ack` is high on a load; 0 otherwise.
- `cpu_error`  output  1  high with `cpu_ack` when the address was out of range.
- `cpu_busy`  output  1  queue holds 2 entries.
- `overflow`  output  1  sticky; set when a request is dropped.

## Operation
- **Queue.** 2 entries. Each entry holds {addr, write, byte_enable, wdata, size}.
  - Push when `cpu_request` is sampled high and the queue is not full.
  - A request made while full is still accepted if a pop happens on the same edge.
  - Otherwise the request is dropped, `overflow` is set to 1, and nothing else changes.
- **FSM.**
  - IDLE: if the queue is non-empty, load the wait counter with WAIT_STATES. Go to RESPOND if WAIT_STATES = 0, else go to WAIT.
  - WAIT: decrement the counter; go to RESPOND when it reaches 0.
  - RESPOND: perform the access on this edge and pop the head. Go to WAIT (counter reloaded) if another entry remains, else go to IDLE.
- **Range check.** The address is in range iff `BASE_ADDR <= addr < BASE_ADDR + 4·2^ADDR_WIDTH`. RAM index is `addr[ADDR_WIDTH+1:2]` relative to the base.
- **Access on the RESPOND edge.**
  - Store, in range: write the enabled bytes only. `cpu_ack` = 1, `cpu_rdata` = 0.
  - Load, in range: `cpu_rdata` = RAM word as it was before this edge, `cpu_ack` = 1.
  - Out of range: no RAM change, `cpu_rdata` = 0, `cpu_ack` = 1, `cpu_error` = 1.
- **Ordering.** A load queued behind a store to the same word returns the stored data.
- **Alignment.** Misaligned addresses are not checked; the low two address bits are ignored.
- **RAM contents.** Not cleared by reset; simulation initialises them to 0.

## Timing
- **Reset values.** `cpu_ack`, `cpu_rdata`, `cpu_error`, `cpu_busy`, `overflow` are all 0. Queue is empty, FSM is in IDLE.
- **Latency.** Request sampled at edge E with the queue empty gives `cpu_ack` high during the cycle after edge E+1+WAIT_STATES.
  - WAIT_STATES = 0 gives a 2-cycle latency.
- **Throughput.** Back-to-back accesses complete one per WAIT_STATES+1 cycles. With WAIT_STATES = 0, acks are contiguous.
- **Outputs.** All outputs are registered. `cpu_busy` is derived from the registered count; the CPU must not issue requests while it is high.
- **Reset mid-operation.** Asserting reset abandons queued and in-flight entries. No write occurs unless its RESPOND edge has already passed. No ack is issued for abandoned entries.
- **Deassertion.** Reset deassertion is synchronised externally. The first request is accepted on the first edge after release.

## Test plan
- **Store then load, word.** WAIT_STATES = 1. Store word 0xDEADBEEF to 0x10 (be = 1111), then load 0x10 one cycle later. Expect two acks; the second has rdata = 0xDEADBEEF and error = 0.
- **Byte store merge.** After the first test, store byte 0x55 to 0x12 (be = 0100, wdata = 0x00550000), then load 0x10. Expect rdata = 0xDE55BEEF.
- **Out of range.** Load 0x0001_0000 with ADDR_WIDTH = 14. Expect an ack with error = 1 and rdata = 0. The RAM is unchanged; a later load of 0x0 still returns 0.
- **Queue full / overflow.** WAIT_STATES = 3. Issue 3 requests on consecutive cycles. Expect busy = 1 after the second, the third dropped, overflow = 1, and exactly 2 acks.
- **Zero-wait streaming.** WAIT_STATES = 0. Issue 4 loads, one every cycle, with the CPU respecting busy. Expect acks on 4 consecutive cycles, in order.
- **Reset mid-operation.** WAIT_STATES = 3. Store 0x12345678 to 0x20, then pull reset low during WAIT. Expect no ack, all outputs 0. After release, a load of 0x20 returns the old contents (0).

Source files
------------

// File: rtl/dmem_responder_if.sv
// CPU data-bus bundle between the execute stage (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
    logic        cpu_request;
    logic [31:0] cpu_addr;
    logic        cpu_write;
    logic [3:0]  cpu_byte_enable;
    logic [31:0] cpu_wdata;
    logic [1:0]  cpu_size;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic        cpu_error;
    logic        cpu_busy;
    logic        overflow;

    modport master (
        output cpu_request, cpu_addr, cpu_write, cpu_byte_enable, cpu_wdata, cpu_size,
        input  cpu_ack, cpu_rdata, cpu_error, cpu_busy, overflow
    );

    modport slave (
        input  cpu_request, cpu_addr, cpu_write, cpu_byte_enable, cpu_wdata, cpu_size,
        output cpu_ack, cpu_rdata, cpu_error, cpu_busy, overflow
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: 2-entry in-order request queue in front of a
// word-organised RAM with programmable wait states and range checking.
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH  = 14,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input logic             clock,
    input logic             reset,
    dmem_responder_if.slave bus
);
    localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [32:0] BASE_EXT  = {1'b0, BASE_ADDR};
    localparam logic [32:0] SPAN      = 33'd4 << ADDR_WIDTH;
    localparam logic [2:0]  WAIT_INIT = 3'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESPOND
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [3:0]  byte_enable;
        logic [31:0] wdata;
        logic [1:0]  size;
    } entry_t;

    entry_t                queue [2];
    entry_t                incoming;
    entry_t                head_entry;
    logic                  head;
    logic                  tail;
    logic [1:0]            count;
    logic                  push;
    logic                  pop;
    logic [32:0]           byte_offset;
    logic                  in_range;
    logic                  do_write;
    logic [ADDR_WIDTH-1:0] ram_index;
    logic [31:0]           ram [DEPTH];
    logic                  unused_size;

    state_t                state;
    state_t                state_next;
    logic [2:0]            wait_cnt;
    logic [2:0]            wait_next;

    logic                  ack_q;
    logic [31:0]           rdata_q;
    logic                  error_q;
    logic                  overflow_q;

    assign incoming = '{
        addr:        bus.cpu_addr,
        write:       bus.cpu_write,
        byte_enable: bus.cpu_byte_enable,
        wdata:       bus.cpu_wdata,
        size:        bus.cpu_size
    };

    // With two slots the tail sits one past the head exactly when one entry is held.
    assign tail       = head ^ count[0];
    assign head_entry = queue[head];
    assign pop        = (state == ST_RESPOND);
    assign push       = bus.cpu_request && (!count[1] || pop);

    // Addresses below the base wrap to a huge 33-bit offset and fail the span test.
    assign byte_offset = {1'b0, head_entry.addr} - BASE_EXT;
    assign in_range    = (byte_offset < SPAN);
    assign ram_index   = ADDR_WIDTH'(byte_offset >> 2);
    assign do_write    = pop && head_entry.write && in_range;
    assign unused_size = ^head_entry.size;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            wait_cnt <= 3'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    // An arriving request counts as queued so a zero-wait access answers two cycles later.
    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        case (state)
            ST_IDLE: begin
                if ((count != 2'd0) || push) begin
                    wait_next  = WAIT_INIT;
                    state_next = (WAIT_INIT == 3'd0) ? ST_RESPOND : ST_WAIT;
                end
            end
            ST_WAIT: begin
                wait_next = wait_cnt - 3'd1;
                if (wait_cnt == 3'd1) begin
                    state_next = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                if (count[1] || push) begin
                    wait_next  = WAIT_INIT;
                    state_next = (WAIT_INIT == 3'd0) ? ST_RESPOND : ST_WAIT;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head       <= 1'b0;
            count      <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            if (pop) begin
                head <= ~head;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (bus.cpu_request && !push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Queue payload needs no reset; occupancy is tracked by head/count alone.
    always_ff @(posedge clock) begin
        if (push) begin
            queue[tail] <= incoming;
        end
    end

    always_ff @(posedge clock) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (head_entry.byte_enable[b]) begin
                    ram[ram_index][8*b +: 8] <= head_entry.wdata[8*b +: 8];
                end
            end
        end
    end

    // Loads read the pre-edge word; stores and range errors return zero data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ack_q   <= 1'b0;
            rdata_q <= 32'd0;
            error_q <= 1'b0;
        end else begin
            ack_q   <= pop;
            error_q <= pop && !in_range;
            rdata_q <= (pop && !head_entry.write && in_range) ? ram[ram_index] : 32'd0;
        end
    end

    assign bus.cpu_ack   = ack_q;
    assign bus.cpu_rdata = rdata_q;
    assign bus.cpu_error = error_q;
    assign bus.cpu_busy  = count[1];
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (0, 1 and 3 wait states) behind
// a shared driver, a table of single accesses and hand-written corner sequences.
`timescale 1ns/1ps
module tb_dmem_responder;
    logic        clock = 1'b0;
    logic        reset;
    logic        req;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [1:0]  size;
    logic [1:0]  sel;

    always #5 clock = ~clock;

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();
    dmem_responder_if bus3 ();

    assign bus0.cpu_request     = req && (sel == 2'd0);
    assign bus0.cpu_addr        = addr;
    assign bus0.cpu_write       = write;
    assign bus0.cpu_byte_enable = be;
    assign bus0.cpu_wdata       = wdata;
    assign bus0.cpu_size        = size;
    assign bus1.cpu_request     = req && (sel == 2'd1);
    assign bus1.cpu_addr        = addr;
    assign bus1.cpu_write       = write;
    assign bus1.cpu_byte_enable = be;
    assign bus1.cpu_wdata       = wdata;
    assign bus1.cpu_size        = size;
    assign bus3.cpu_request     = req && (sel == 2'd3);
    assign bus3.cpu_addr        = addr;
    assign bus3.cpu_write       = write;
    assign bus3.cpu_byte_enable = be;
    assign bus3.cpu_wdata       = wdata;
    assign bus3.cpu_size        = size;

    dmem_responder #(.ADDR_WIDTH(14), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut_w0 (
        .clock(clock), .reset(reset), .bus(bus0));
    dmem_responder #(.ADDR_WIDTH(14), .BASE_ADDR(32'h0), .WAIT_STATES(1)) dut_w1 (
        .clock(clock), .reset(reset), .bus(bus1));
    dmem_responder #(.ADDR_WIDTH(14), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut_w3 (
        .clock(clock), .reset(reset), .bus(bus3));

    logic        mon_ack;
    logic [31:0] mon_rdata;
    logic        mon_error;
    logic        mon_busy;
    logic        mon_overflow;

    always_comb begin
        mon_ack      = bus3.cpu_ack;
        mon_rdata    = bus3.cpu_rdata;
        mon_error    = bus3.cpu_error;
        mon_busy     = bus3.cpu_busy;
        mon_overflow = bus3.overflow;
        if (sel == 2'd0) begin
            mon_ack      = bus0.cpu_ack;
            mon_rdata    = bus0.cpu_rdata;
            mon_error    = bus0.cpu_error;
            mon_busy     = bus0.cpu_busy;
            mon_overflow = bus0.overflow;
        end else if (sel == 2'd1) begin
            mon_ack      = bus1.cpu_ack;
            mon_rdata    = bus1.cpu_rdata;
            mon_error    = bus1.cpu_error;
            mon_busy     = bus1.cpu_busy;
            mon_overflow = bus1.overflow;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        error;
    } exp_t;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_error;
    } vec_t;

    exp_t sb [$];
    exp_t mon_exp;
    int   ack_cycles [$];
    int   passed    = 0;
    int   total     = 0;
    int   ack_count = 0;
    int   cycle     = 0;
    vec_t vecs [12];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic wr, input logic [31:0] a, input logic [3:0] b,
                                  input logic [31:0] d, input logic [31:0] er, input logic ee,
                                  input logic want_ack);
        exp_t e;
        req   = 1'b1;
        write = wr;
        addr  = a;
        be    = b;
        wdata = d;
        size  = 2'b10;
        if (want_ack) begin
            e.rdata = er;
            e.error = ee;
            sb.push_back(e);
        end
        @(negedge clock);
        req = 1'b0;
    endtask

    task automatic single_access(input string name, input logic wr, input logic [31:0] a,
                                 input logic [3:0] b, input logic [31:0] d, input logic [31:0] er,
                                 input logic ee, input int lat);
        int k;
        apply_stimulus(wr, a, b, d, er, ee, 1'b1);
        k = 1;
        while (!mon_ack && k < 40) begin
            @(negedge clock);
            k++;
        end
        check_output({name, "_latency"}, 32'(k), 32'(lat));
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge clock);
            k++;
        end
        check_output(name, 32'(sb.size()), 32'd0);
        @(negedge clock);
    endtask

    always @(posedge clock) cycle++;

    always @(negedge clock) begin
        if (reset && mon_ack) begin
            ack_count++;
            ack_cycles.push_back(cycle);
            if (sb.size() == 0) begin
                total++;
                $display("[TB] FAIL unexpected_ack: got ack (rdata 0x%08h) with nothing outstanding", mon_rdata);
            end else begin
                mon_exp = sb.pop_front();
                check_output("ack_rdata", mon_rdata, mon_exp.rdata);
                check_output("ack_error", 32'(mon_error), 32'(mon_exp.error));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a0;
        int base;

        vecs[0]  = '{1'b1, 32'h0000_0000, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0012, 4'b0100, 32'h0055_0000, 32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0000_0000, 32'hDE55_BEEF, 1'b0};
        vecs[5]  = '{1'b0, 32'h0001_0000, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[6]  = '{1'b1, 32'h0001_0000, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[7]  = '{1'b0, 32'h0000_0000, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[8]  = '{1'b0, 32'h0000_0013, 4'h0, 32'h0000_0000, 32'hDE55_BEEF, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_FFFC, 4'hF, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
        vecs[10] = '{1'b0, 32'h0000_FFFE, 4'h0, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
        vecs[11] = '{1'b0, 32'hFFFF_FFFC, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1};

        req = 1'b0; write = 1'b0; addr = 32'd0; be = 4'd0; wdata = 32'd0; size = 2'd0;
        sel = 2'd1;
        reset = 1'b0;
        repeat (3) @(negedge clock);

        for (int s = 0; s < 4; s++) begin
            if (s != 2) begin
                sel = 2'(s);
                #1;
                check_output("reset_ack", 32'(mon_ack), 32'd0);
                check_output("reset_rdata", mon_rdata, 32'd0);
                check_output("reset_error", 32'(mon_error), 32'd0);
                check_output("reset_busy", 32'(mon_busy), 32'd0);
                check_output("reset_overflow", 32'(mon_overflow), 32'd0);
            end
        end
        sel = 2'd1;
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            single_access($sformatf("vec%0d", i), vecs[i].write, vecs[i].addr, vecs[i].be,
                          vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_error, 3);
        end
        drain("table_drain");

        apply_stimulus(1'b1, 32'h18, 4'hF, 32'h0BAD_CAFE, 32'h0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 32'h18, 4'h0, 32'h0, 32'h0BAD_CAFE, 1'b0, 1'b1);
        check_output("order_busy", 32'(mon_busy), 32'd1);
        drain("order_drain");

        sel = 2'd0;
        single_access("w0_store", 1'b1, 32'h100, 4'hF, 32'hA000_0000, 32'h0, 1'b0, 2);
        for (int i = 1; i < 4; i++) begin
            int g;
            g = 0;
            while (mon_busy && g < 20) begin
                @(negedge clock);
                g++;
            end
            apply_stimulus(1'b1, 32'h100 + 32'(4 * i), 4'hF, 32'hA000_0000 + 32'(i), 32'h0, 1'b0, 1'b1);
        end
        drain("w0_store_drain");
        base = ack_cycles.size();
        for (int i = 0; i < 4; i++) begin
            int g;
            g = 0;
            while (mon_busy && g < 20) begin
                @(negedge clock);
                g++;
            end
            apply_stimulus(1'b0, 32'h100 + 32'(4 * i), 4'h0, 32'h0, 32'hA000_0000 + 32'(i), 1'b0, 1'b1);
        end
        drain("w0_load_drain");
        check_output("w0_ack_total", 32'(ack_cycles.size() - base), 32'd4);
        if (ack_cycles.size() - base == 4) begin
            for (int i = 1; i < 4; i++) begin
                check_output($sformatf("w0_contiguous%0d", i),
                             32'(ack_cycles[base + i] - ack_cycles[base + i - 1]), 32'd1);
            end
        end

        sel = 2'd3;
        @(negedge clock);
        a0 = ack_count;
        apply_stimulus(1'b1, 32'h40, 4'hF, 32'h1111_1111, 32'h0, 1'b0, 1'b1);
        apply_stimulus(1'b1, 32'h44, 4'hF, 32'h2222_2222, 32'h0, 1'b0, 1'b1);
        check_output("ovf_busy_after_second", 32'(mon_busy), 32'd1);
        apply_stimulus(1'b1, 32'h48, 4'hF, 32'h3333_3333, 32'h0, 1'b0, 1'b0);
        check_output("ovf_flag", 32'(mon_overflow), 32'd1);
        repeat (20) @(negedge clock);
        check_output("ovf_ack_count", 32'(ack_count - a0), 32'd2);
        check_output("ovf_busy_cleared", 32'(mon_busy), 32'd0);
        single_access("ovf_load44", 1'b0, 32'h44, 4'h0, 32'h0, 32'h2222_2222, 1'b0, 5);
        single_access("ovf_load40", 1'b0, 32'h40, 4'h0, 32'h0, 32'h1111_1111, 1'b0, 5);
        check_output("ovf_sticky", 32'(mon_overflow), 32'd1);

        single_access("rst_prep", 1'b1, 32'h20, 4'hF, 32'h0, 32'h0, 1'b0, 5);
        drain("rst_prep_drain");
        a0 = ack_count;
        apply_stimulus(1'b1, 32'h20, 4'hF, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_output("rst_mid_ack", 32'(mon_ack), 32'd0);
        check_output("rst_mid_rdata", mon_rdata, 32'd0);
        check_output("rst_mid_error", 32'(mon_error), 32'd0);
        check_output("rst_mid_busy", 32'(mon_busy), 32'd0);
        check_output("rst_mid_overflow", 32'(mon_overflow), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        single_access("rst_reload", 1'b0, 32'h20, 4'h0, 32'h0, 32'h0, 1'b0, 5);
        repeat (10) @(negedge clock);
        check_output("rst_ack_count", 32'(ack_count - a0), 32'd1);

        drain("final_drain");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
